// File: rtl/axi_slv_mem.sv
// AXI4 slave responder backed by an internal dual-port RAM, used as the far end of bandwidth tests.
// Independent single-outstanding INCR read and write paths plus free-running accepted-beat counters.
`timescale 1ns/1ps
module axi_slv_mem #(
  parameter int ID_WIDTH       = 1,
  parameter int DATA_WIDTH     = 64,
  parameter int B_BURST_LENGTH = 8,
  parameter int MEM_AW         = 12
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_areset,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [31:0]               s_axi_awaddr,
  input  logic [B_BURST_LENGTH-1:0] s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awlock,
  input  logic [3:0]                s_axi_awcache,
  input  logic [2:0]                s_axi_awprot,
  input  logic [3:0]                s_axi_awregion,
  input  logic [3:0]                s_axi_awqos,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [31:0]               s_axi_araddr,
  input  logic [B_BURST_LENGTH-1:0] s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic [3:0]                s_axi_arregion,
  input  logic [3:0]                s_axi_arqos,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [31:0]               WBEATS_REG,
  output logic [31:0]               RBEATS_REG
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BL     = $clog2(STRB_W);
  localparam int DEPTH  = 2 ** MEM_AW;
  localparam int LEN_W  = B_BURST_LENGTH;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wrState_t;
  typedef enum logic {R_IDLE, R_BURST} rdState_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  rstDone_q;

  wrState_t              wrState_q, wrState_d;
  logic [ID_WIDTH-1:0]   wrId_q;
  logic [MEM_AW-1:0]     wrAddr_q;
  logic [LEN_W-1:0]      wrLen_q, wrCnt_q;
  logic                  wrErr_q;
  logic [31:0]           wBeats_q;
  logic                  awHs, wHs, wrLastBeat;

  rdState_t              rdState_q, rdState_d;
  logic [ID_WIDTH-1:0]   rdId_q;
  logic [MEM_AW-1:0]     rdAddr_q;
  logic [LEN_W-1:0]      rdLen_q;
  logic [LEN_W:0]        issueCnt_q;
  logic [DATA_WIDTH-1:0] skidData_q [2];
  logic [1:0]            skidLast_q;
  logic                  skidWrPtr_q, skidRdPtr_q;
  logic [1:0]            skidCnt_q;
  logic [31:0]           rBeats_q;
  logic                  arHs, rHs, rdIssue, issueLast;

  logic                  unusedInputs;
  assign unusedInputs = ^{s_axi_awaddr[31:MEM_AW+BL], s_axi_awaddr[BL-1:0],
                          s_axi_araddr[31:MEM_AW+BL], s_axi_araddr[BL-1:0],
                          s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                          s_axi_awprot, s_axi_awregion, s_axi_awqos,
                          s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                          s_axi_arprot, s_axi_arregion, s_axi_arqos};

  // Address-ready stays low for the first cycle after reset release.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) rstDone_q <= 1'b0;
    else              rstDone_q <= 1'b1;
  end

  assign s_axi_awready = rstDone_q && (wrState_q == W_IDLE);
  assign s_axi_wready  = (wrState_q == W_DATA);
  assign s_axi_bvalid  = (wrState_q == W_RESP);
  assign s_axi_bid     = wrId_q;
  assign s_axi_bresp   = (s_axi_bvalid && wrErr_q) ? 2'b10 : 2'b00;
  assign awHs          = s_axi_awvalid && s_axi_awready;
  assign wHs           = s_axi_wvalid && s_axi_wready;
  assign wrLastBeat    = (wrCnt_q == wrLen_q);
  assign WBEATS_REG    = wBeats_q;

  always_comb begin
    wrState_d = wrState_q;
    unique case (wrState_q)
      W_IDLE:  if (awHs) wrState_d = W_DATA;
      W_DATA:  if (wHs && wrLastBeat) wrState_d = W_RESP;
      W_RESP:  if (s_axi_bready) wrState_d = W_IDLE;
      default: wrState_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wrState_q <= W_IDLE;
      wrId_q    <= '0;
      wrAddr_q  <= '0;
      wrLen_q   <= '0;
      wrCnt_q   <= '0;
      wrErr_q   <= 1'b0;
      wBeats_q  <= '0;
    end else begin
      wrState_q <= wrState_d;
      if (awHs) begin
        wrId_q   <= s_axi_awid;
        wrAddr_q <= s_axi_awaddr[MEM_AW+BL-1:BL];
        wrLen_q  <= s_axi_awlen;
        wrCnt_q  <= '0;
        wrErr_q  <= 1'b0;
      end
      // The burst length comes from AWLEN; a misplaced WLAST only flags the response.
      if (wHs) begin
        wrAddr_q <= wrAddr_q + MEM_AW'(1);
        wrCnt_q  <= wrCnt_q + LEN_W'(1);
        wBeats_q <= wBeats_q + 32'd1;
        if (s_axi_wlast != wrLastBeat) wrErr_q <= 1'b1;
      end
    end
  end

  assign s_axi_arready = rstDone_q && (rdState_q == R_IDLE);
  assign arHs          = s_axi_arvalid && s_axi_arready;
  assign s_axi_rvalid  = (skidCnt_q != 2'd0);
  assign rHs           = s_axi_rvalid && s_axi_rready;
  assign s_axi_rdata   = skidData_q[skidRdPtr_q];
  assign s_axi_rlast   = skidLast_q[skidRdPtr_q];
  assign s_axi_rid     = rdId_q;
  assign s_axi_rresp   = 2'b00;
  assign RBEATS_REG    = rBeats_q;
  assign issueLast     = (issueCnt_q == {1'b0, rdLen_q});
  // A RAM read lands in the skid buffer next cycle, so issue only if a slot is free after this cycle.
  assign rdIssue       = (rdState_q == R_BURST) && (issueCnt_q <= {1'b0, rdLen_q}) &&
                         ((skidCnt_q != 2'd2) || rHs);

  always_comb begin
    rdState_d = rdState_q;
    unique case (rdState_q)
      R_IDLE:  if (arHs) rdState_d = R_BURST;
      R_BURST: if (rHs && s_axi_rlast) rdState_d = R_IDLE;
      default: rdState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rdState_q   <= R_IDLE;
      rdId_q      <= '0;
      rdAddr_q    <= '0;
      rdLen_q     <= '0;
      issueCnt_q  <= '0;
      skidLast_q  <= '0;
      skidWrPtr_q <= 1'b0;
      skidRdPtr_q <= 1'b0;
      skidCnt_q   <= '0;
      rBeats_q    <= '0;
    end else begin
      rdState_q <= rdState_d;
      if (arHs) begin
        rdId_q     <= s_axi_arid;
        rdAddr_q   <= s_axi_araddr[MEM_AW+BL-1:BL];
        rdLen_q    <= s_axi_arlen;
        issueCnt_q <= '0;
      end
      if (rdIssue) begin
        rdAddr_q                <= rdAddr_q + MEM_AW'(1);
        issueCnt_q              <= issueCnt_q + (LEN_W+1)'(1);
        skidLast_q[skidWrPtr_q] <= issueLast;
        skidWrPtr_q             <= ~skidWrPtr_q;
      end
      if (rHs) begin
        skidRdPtr_q <= ~skidRdPtr_q;
        rBeats_q    <= rBeats_q + 32'd1;
      end
      skidCnt_q <= skidCnt_q + {1'b0, rdIssue} - {1'b0, rHs};
    end
  end

  // RAM storage is never reset; a read of a word written this cycle returns the old contents.
  always_ff @(posedge s_axi_aclk) begin
    if (wHs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[wrAddr_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
    if (rdIssue) skidData_q[skidWrPtr_q] <= mem[rdAddr_q];
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Scoreboard bench for axi_slv_mem: tasks push expected B/R responses from a word-array model,
// a monitor process pops and compares them whenever the DUT completes a handshake.
`timescale 1ns/1ps
module tb_axi_slv_mem;
  localparam int IDW = 1, DW = 64, LW = 8, MAW = 12, DEPTH = 4096;

  logic clock = 1'b0;
  logic reset;
  logic [IDW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [LW-1:0] s_axi_awlen, s_axi_arlen;
  logic [2:0] s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0] s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic s_axi_awlock, s_axi_arlock;
  logic [3:0] s_axi_awcache, s_axi_arcache, s_axi_awregion, s_axi_arregion, s_axi_awqos, s_axi_arqos;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic [31:0] WBEATS_REG, RBEATS_REG;

  always #5 clock = ~clock;

  axi_slv_mem #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .B_BURST_LENGTH(LW), .MEM_AW(MAW)) dut (
    .s_axi_aclk(clock), .s_axi_areset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awregion(s_axi_awregion),
    .s_axi_awqos(s_axi_awqos), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arregion(s_axi_arregion),
    .s_axi_arqos(s_axi_arqos), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .WBEATS_REG(WBEATS_REG), .RBEATS_REG(RBEATS_REG)
  );

  typedef struct { logic [DW-1:0] data; logic last; logic [IDW-1:0] id; } rExp_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } bExp_t;

  rExp_t rQ[$];
  bExp_t bQ[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wrData [256];
  int compared = 0, mismatched = 0;
  int unsigned expW = 0, expR = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Monitor: compares every completed R/B handshake against the scoreboard and checks R stalls hold data.
  initial begin : monitor
    logic stallPrev;
    logic [DW-1:0] dPrev;
    logic lPrev;
    rExp_t re;
    bExp_t be;
    stallPrev = 1'b0;
    dPrev = '0;
    lPrev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) stallPrev = 1'b0;
      else begin
        if (stallPrev) begin
          checkOutput("rvalid_held", s_axi_rvalid, 1);
          checkOutput("rdata_held", s_axi_rdata, dPrev);
          checkOutput("rlast_held", s_axi_rlast, lPrev);
        end
        if (s_axi_rvalid && s_axi_rready) begin
          if (rQ.size() == 0) reportFail("r_unexpected", "got an R beat, expected none");
          else begin
            re = rQ.pop_front();
            checkOutput("rdata", s_axi_rdata, re.data);
            checkOutput("rlast", s_axi_rlast, re.last);
            checkOutput("rid", s_axi_rid, re.id);
            checkOutput("rresp", s_axi_rresp, 0);
          end
        end
        stallPrev = s_axi_rvalid && !s_axi_rready;
        dPrev = s_axi_rdata;
        lPrev = s_axi_rlast;
        if (s_axi_bvalid && s_axi_bready) begin
          if (bQ.size() == 0) reportFail("b_unexpected", "got a B response, expected none");
          else begin
            be = bQ.pop_front();
            checkOutput("bid", s_axi_bid, be.id);
            checkOutput("bresp", s_axi_bresp, be.resp);
          end
        end
      end
    end
  end

  task automatic writeBurst(input logic [IDW-1:0] id, input int word, input int len, input logic [7:0] strb,
                            input int lastBeat, input logic [31:0] noise, input bit gaps, output int awWait);
    int cyc, w;
    bit err;
    awWait = -1;
    err = (lastBeat != len);
    for (int i = 0; i <= len; i++) begin
      w = (word + i) % DEPTH;
      for (int b = 0; b < 8; b++) if (strb[b]) model[w][b*8 +: 8] = wrData[i][b*8 +: 8];
    end
    bQ.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
    expW += len + 1;
    @(posedge clock); #1;
    s_axi_awid = id;
    s_axi_awaddr = (noise & 32'hFFFF_8007) | (32'(word) << 3);
    s_axi_awlen = LW'(len);
    s_axi_awvalid = 1'b1;
    cyc = 0;
    @(negedge clock);
    while (!s_axi_awready && cyc < 200) begin @(negedge clock); cyc++; end
    if (!s_axi_awready) begin reportFail("aw_timeout", "no AW handshake within 200 cycles"); s_axi_awvalid = 1'b0; return; end
    awWait = cyc;
    @(posedge clock); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && i != 0 && $urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 1'b0;
        @(posedge clock); #1;
      end
      s_axi_wvalid = 1'b1;
      s_axi_wdata = wrData[i];
      s_axi_wstrb = strb;
      s_axi_wlast = (i == lastBeat);
      cyc = 0;
      @(negedge clock);
      if (i == 0) checkOutput("wready_after_aw", s_axi_wready, 1);
      while (!s_axi_wready && cyc < 200) begin @(negedge clock); cyc++; end
      if (!s_axi_wready) begin reportFail("w_timeout", "W beat not accepted within 200 cycles"); break; end
      @(posedge clock); #1;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast = 1'b0;
    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    s_axi_bready = 1'b1;
    cyc = 0;
    @(negedge clock);
    while (!s_axi_bvalid && cyc < 200) begin @(negedge clock); cyc++; end
    if (!s_axi_bvalid) reportFail("b_timeout", "no B response within 200 cycles");
    @(posedge clock); #1;
    s_axi_bready = 1'b0;
    @(negedge clock);
    checkOutput("wbeats_count", WBEATS_REG, expW);
  endtask

  // mode 0: rready held 1, mode 1: rready toggles 1010.., mode 2: random rready.
  task automatic readBurst(input logic [IDW-1:0] id, input int word, input int len, input int mode,
                           input logic [31:0] noise, output int arWait);
    int cyc, k, beats;
    arWait = -1;
    for (int i = 0; i <= len; i++) rQ.push_back('{data: model[(word + i) % DEPTH], last: (i == len), id: id});
    expR += len + 1;
    @(posedge clock); #1;
    s_axi_rready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    s_axi_arid = id;
    s_axi_araddr = (noise & 32'hFFFF_8007) | (32'(word) << 3);
    s_axi_arlen = LW'(len);
    s_axi_arvalid = 1'b1;
    cyc = 0;
    @(negedge clock);
    while (!s_axi_arready && cyc < 200) begin @(negedge clock); cyc++; end
    if (!s_axi_arready) begin reportFail("ar_timeout", "no AR handshake within 200 cycles"); s_axi_arvalid = 1'b0; return; end
    arWait = cyc;
    @(posedge clock); #1;
    s_axi_arvalid = 1'b0;
    beats = 0;
    k = 0;
    while (beats <= len && k < 3000) begin
      @(negedge clock);
      k++;
      if (k == 1) checkOutput("rvalid_before_latency", s_axi_rvalid, 0);
      if (k == 2) checkOutput("rvalid_at_ar_plus_2", s_axi_rvalid, 1);
      if (s_axi_rvalid && s_axi_rready) beats++;
      @(posedge clock); #1;
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = ~s_axi_rready;
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
    end
    if (beats <= len) reportFail("r_timeout", "R burst incomplete after 3000 cycles");
    else if (mode == 0) checkOutput("r_back_to_back_cycles", k, len + 2);
    s_axi_rready = 1'b0;
    @(negedge clock);
    checkOutput("rbeats_count", RBEATS_REG, expR);
  endtask

  task automatic applyStimulus(input int count);
    int word, len, lastBeat, wt;
    for (int t = 0; t < count; t++) begin
      word = $urandom_range(0, DEPTH - 1);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) wrData[i] = {$urandom, $urandom};
        lastBeat = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len;
        writeBurst(IDW'($urandom), word, len, 8'($urandom), lastBeat, $urandom, 1'b1, wt);
      end else begin
        readBurst(IDW'($urandom), word, len, $urandom_range(0, 2), $urandom, wt);
      end
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int awWait, arWait;
    reset = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
    s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awregion = '0; s_axi_awqos = '0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3; s_axi_arburst = 2'b01;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arregion = '0; s_axi_arqos = '0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_awready", s_axi_awready, 0);
    checkOutput("reset_arready", s_axi_arready, 0);
    checkOutput("reset_wready", s_axi_wready, 0);
    checkOutput("reset_bvalid", s_axi_bvalid, 0);
    checkOutput("reset_rvalid", s_axi_rvalid, 0);
    checkOutput("reset_bresp", s_axi_bresp, 0);
    checkOutput("reset_wbeats", WBEATS_REG, 0);
    checkOutput("reset_rbeats", RBEATS_REG, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("awready_release_cycle", s_axi_awready, 0);
    @(negedge clock);
    checkOutput("awready_idle", s_axi_awready, 1);
    checkOutput("arready_idle", s_axi_arready, 1);

    // Directed: 8-beat write/read at 0x100, stalled readback, short WLAST, strobes, wrap.
    for (int i = 0; i < 8; i++) wrData[i] = DW'(i);
    writeBurst(1'b1, 32'h100 >> 3, 7, 8'hFF, 7, 32'h0, 1'b0, awWait);
    readBurst(1'b1, 32'h100 >> 3, 7, 0, 32'h0, arWait);
    readBurst(1'b0, 32'h100 >> 3, 7, 1, 32'h0, arWait);
    for (int i = 0; i < 4; i++) wrData[i] = {32'hA5A5_0000, 32'(i)};
    writeBurst(1'b0, 'h40, 3, 8'hFF, 2, 32'h0, 1'b0, awWait);
    readBurst(1'b0, 'h40, 3, 0, 32'h0, arWait);
    wrData[0] = '1;
    writeBurst(1'b0, 'h50, 0, 8'hFF, 0, 32'h0, 1'b0, awWait);
    wrData[0] = '0;
    writeBurst(1'b1, 'h50, 0, 8'h0F, 0, 32'h0, 1'b0, awWait);
    readBurst(1'b1, 'h50, 0, 0, 32'h0, arWait);
    for (int i = 0; i < 4; i++) wrData[i] = {$urandom, $urandom};
    writeBurst(1'b1, DEPTH - 2, 3, 8'hFF, 3, $urandom, 1'b1, awWait);
    readBurst(1'b0, DEPTH - 2, 3, 2, $urandom, arWait);

    // Fill the whole RAM so later random reads have known contents.
    for (int blk = 0; blk < DEPTH / 256; blk++) begin
      for (int i = 0; i < 256; i++) wrData[i] = {$urandom, $urandom};
      writeBurst(1'b0, blk * 256, 255, 8'hFF, 255, $urandom, 1'b0, awWait);
    end

    // Simultaneous AW and AR on disjoint regions are both accepted at once.
    for (int i = 0; i < 16; i++) wrData[i] = {$urandom, $urandom};
    fork
      writeBurst(1'b1, 'h800, 15, 8'hFF, 15, 32'h0, 1'b0, awWait);
      readBurst(1'b0, 'h900, 15, 0, 32'h0, arWait);
    join
    checkOutput("concurrent_aw_wait", awWait, 0);
    checkOutput("concurrent_ar_wait", arWait, 0);

    // Reset in the middle of a read burst: R stops at once, no completion, counters cleared.
    for (int i = 0; i <= 20; i++) rQ.push_back('{data: model[('h300 + i) % DEPTH], last: (i == 20), id: 1'b1});
    @(posedge clock); #1;
    s_axi_rready = 1'b1;
    s_axi_arid = 1'b1; s_axi_araddr = 32'h300 << 3; s_axi_arlen = 8'd20; s_axi_arvalid = 1'b1;
    @(negedge clock);
    checkOutput("midreset_ar_accept", s_axi_arready, 1);
    @(posedge clock); #1;
    s_axi_arvalid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    checkOutput("rvalid_on_reset", s_axi_rvalid, 0);
    checkOutput("arready_in_reset", s_axi_arready, 0);
    rQ.delete();
    expW = 0;
    expR = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    s_axi_rready = 1'b0;
    @(negedge clock);
    checkOutput("awready_after_release", s_axi_awready, 0);
    @(negedge clock);
    checkOutput("arready_after_release", s_axi_arready, 1);
    checkOutput("rvalid_after_release", s_axi_rvalid, 0);
    checkOutput("wbeats_after_reset", WBEATS_REG, 0);
    checkOutput("rbeats_after_reset", RBEATS_REG, 0);

    applyStimulus(40);

    repeat (5) @(posedge clock);
    @(negedge clock);
    checkOutput("r_scoreboard_drained", rQ.size(), 0);
    checkOutput("b_scoreboard_drained", bQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
